// File: rtl/sys_board_io.sv
// Board front end for the MIPS core: synchronised, debounced keys; step/run clock enables; PC load, LED view, sticky error.
// Define BOARD_IO_HEARTBEAT_EN to add the hb_led output driven by a free-running divider.
module sys_board_io #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_DIV        = 25000000,
  parameter int PC_WIDTH        = 8,
  parameter int NUM_CH          = 8,
  parameter int CH_WIDTH        = 32,
  parameter int LED_WIDTH       = 8,
  localparam int SEL_W          = $clog2(NUM_CH) + $clog2(CH_WIDTH / LED_WIDTH)
) (
  input  logic                         SYS_clk_in,
  input  logic                         SYS_rst,
  input  logic [NUM_KEYS-1:0]          key_n,
  input  logic [PC_WIDTH-1:0]          sw_pc_val,
  input  logic                         sw_load,
  input  logic [SEL_W-1:0]             sw_sel,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic                         err_in,
  output logic                         step_en,
  output logic                         run_mode,
  output logic                         pc_load,
  output logic [PC_WIDTH-1:0]          pc_val,
  output logic [NUM_KEYS-1:0]          key_press,
  output logic [LED_WIDTH-1:0]         leds,
  output logic                         err_led
`ifdef BOARD_IO_HEARTBEAT_EN
  ,output logic                        hb_led
`endif
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(AUTO_DIV);
  localparam int LANES = CH_WIDTH / LED_WIDTH;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(AUTO_DIV - 1);

  typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} mode_t;

  logic [NUM_KEYS-1:0]  r_key_s1, r_key_s2, r_key_stable_d, r_key_press;
  logic [NUM_KEYS-1:0]  w_key_stable;
  logic [PC_WIDTH-1:0]  r_pc_s1, r_pc_s2, r_pc_val;
  logic                 r_load_s1, r_load_s2, r_load_d, r_pc_load;
  logic [SEL_W-1:0]     r_sel_s1, r_sel_s2;
  logic [LED_WIDTH-1:0] r_leds;
  logic                 r_err;
  mode_t                r_mode, w_mode_next;
  logic [DIV_W-1:0]     r_div;
  logic [LED_WIDTH-1:0] w_lane_arr [NUM_CH*LANES];

  // Keys idle high (released), so their synchronisers reset to 1.
  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_key_s1  <= '1;
      r_key_s2  <= '1;
      r_pc_s1   <= '0;
      r_pc_s2   <= '0;
      r_load_s1 <= 1'b0;
      r_load_s2 <= 1'b0;
      r_sel_s1  <= '0;
      r_sel_s2  <= '0;
    end else begin
      r_key_s1  <= key_n;
      r_key_s2  <= r_key_s1;
      r_pc_s1   <= sw_pc_val;
      r_pc_s2   <= r_pc_s1;
      r_load_s1 <= sw_load;
      r_load_s2 <= r_load_s1;
      r_sel_s1  <= sw_sel;
      r_sel_s2  <= r_sel_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_stable;
      always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
        if (!SYS_rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b1;
        end else if (r_key_s2[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_MAX) begin
          r_stable <= r_key_s2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_key_stable[gi] = r_stable;
    end
  endgenerate

  // Press pulse lands the cycle after the debounced level falls.
  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_key_stable_d <= '1;
      r_key_press    <= '0;
    end else begin
      r_key_stable_d <= w_key_stable;
      r_key_press    <= r_key_stable_d & ~w_key_stable;
    end
  end

  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_mode <= ST_STEP;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    if (r_key_press[1]) begin
      w_mode_next = (r_mode == ST_STEP) ? ST_RUN : ST_STEP;
    end
  end

  // Divider only runs in run mode and restarts from 0 on every mode change.
  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_div <= '0;
    end else if (r_key_press[1] || (r_mode == ST_STEP) || (r_div == DIV_MAX)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign step_en  = ~r_key_press[1] &
                    ((r_mode == ST_RUN) ? (r_div == DIV_MAX) : r_key_press[0]);
  assign run_mode = (r_mode == ST_RUN);

  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_load_d  <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_val  <= '0;
    end else begin
      r_load_d  <= r_load_s2;
      r_pc_load <= r_load_s2 & ~r_load_d;
      if (r_load_s2 && !r_load_d) begin
        r_pc_val <= r_pc_s2;
      end
    end
  end

  // Lane k of the flattened bus is channel k/LANES, byte k%LANES, so sw_sel indexes it directly.
  generate
    for (gi = 0; gi < NUM_CH * LANES; gi++) begin : g_lane
      assign w_lane_arr[gi] = ch_data[gi*LED_WIDTH +: LED_WIDTH];
    end
  endgenerate

  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_leds <= '0;
      r_err  <= 1'b0;
    end else begin
      r_leds <= w_lane_arr[r_sel_s2];
      if (err_in) begin
        r_err <= 1'b1;
      end else if (r_key_press[2]) begin
        r_err <= 1'b0;
      end
    end
  end

  assign key_press = r_key_press;
  assign pc_load   = r_pc_load;
  assign pc_val    = r_pc_val;
  assign leds      = r_leds;
  assign err_led   = r_err;

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [DIV_W-1:0] r_hb_div;
  logic             r_hb;
  always_ff @(posedge SYS_clk_in or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_hb_div <= '0;
      r_hb     <= 1'b0;
    end else if (r_hb_div == DIV_MAX) begin
      r_hb_div <= '0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_div <= r_hb_div + 1'b1;
    end
  end
  assign hb_led = r_hb;
`endif

endmodule

// File: tb/tb_sys_board_io.sv
// Scoreboard bench for sys_board_io: stimulus queues expected pulses/levels by cycle, a negedge monitor compares.
`timescale 1ns/1ps
module tb_sys_board_io;
  localparam int NK = 4, DEB = 4, ADIV = 5, PCW = 8, NCH = 8, CHW = 32, LW = 8, SELW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NK-1:0]        key_n = '1;
  logic [PCW-1:0]       sw_pc_val = '0;
  logic                 sw_load = 1'b0;
  logic [SELW-1:0]      sw_sel = '0;
  logic [NCH*CHW-1:0]   ch_data = '0;
  logic                 err_in = 1'b0;
  logic                 step_en, run_mode, pc_load, err_led;
  logic [PCW-1:0]       pc_val;
  logic [NK-1:0]        key_press;
  logic [LW-1:0]        leds;
`ifdef BOARD_IO_HEARTBEAT_EN
  logic                 hb_led;
`endif

  sys_board_io #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .AUTO_DIV(ADIV), .PC_WIDTH(PCW),
    .NUM_CH(NCH), .CH_WIDTH(CHW), .LED_WIDTH(LW)
  ) dut (
    .SYS_clk_in(clk), .SYS_rst(rst_n), .key_n(key_n), .sw_pc_val(sw_pc_val),
    .sw_load(sw_load), .sw_sel(sw_sel), .ch_data(ch_data), .err_in(err_in),
    .step_en(step_en), .run_mode(run_mode), .pc_load(pc_load), .pc_val(pc_val),
    .key_press(key_press), .leds(leds), .err_led(err_led)
`ifdef BOARD_IO_HEARTBEAT_EN
    , .hb_led(hb_led)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; int val; string name; } lvl_t;
  typedef struct { int cyc; int val; } pls_t;
  lvl_t lvl_q[$];
  pls_t step_q[$];
  pls_t pcl_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // kind: 0 run_mode, 1 leds, 2 err_led, 4 every output packed together (must be all zero)
  function automatic int sample(int kind);
    case (kind)
      0: return int'(run_mode);
      1: return int'(leds);
      2: return int'(err_led);
      default: return int'({step_en, run_mode, pc_load, pc_val, key_press, leds, err_led});
    endcase
  endfunction

  function automatic void exp_lvl(int c, int kind, int val, string nm);
    lvl_t e;
    int idx;
    e.cyc = c; e.kind = kind; e.val = val; e.name = nm;
    idx = lvl_q.size();
    for (int i = 0; i < lvl_q.size(); i++) begin
      if (lvl_q[i].cyc > c) begin idx = i; break; end
    end
    lvl_q.insert(idx, e);
  endfunction

  function automatic void exp_pulse(int which, int c, int val);
    pls_t e;
    e.cyc = c; e.val = val;
    if (which == 0) step_q.push_back(e);
    else pcl_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      lvl_t e;
      int got;
      e = lvl_q.pop_front();
      got = sample(e.kind);
      n_checks++;
      if (e.cyc != cyc || got != e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h, required %0h (cycle %0d, due %0d)", e.name, got, e.val, cyc, e.cyc);
      end else begin
        $display("check %s ok: %0h at cycle %0d", e.name, got, cyc);
      end
    end
    while (step_q.size() > 0 && step_q[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL step_en_missing: got 0, required 1 (due cycle %0d)", step_q[0].cyc);
      void'(step_q.pop_front());
    end
    if (step_en) begin
      n_checks++;
      if (step_q.size() > 0 && step_q[0].cyc == cyc) begin
        void'(step_q.pop_front());
        $display("check step_en ok at cycle %0d", cyc);
      end else begin
        n_fail++;
        $display("FAIL step_en_unexpected: got 1, required 0 (cycle %0d)", cyc);
      end
    end
    while (pcl_q.size() > 0 && pcl_q[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL pc_load_missing: got 0, required 1 (due cycle %0d)", pcl_q[0].cyc);
      void'(pcl_q.pop_front());
    end
    if (pc_load) begin
      n_checks++;
      if (pcl_q.size() > 0 && pcl_q[0].cyc == cyc) begin
        if (int'(pc_val) != pcl_q[0].val) begin
          n_fail++;
          $display("FAIL pc_val: got %0h, required %0h (cycle %0d)", pc_val, pcl_q[0].val, cyc);
        end else begin
          $display("check pc_load ok: pc_val %0h at cycle %0d", pc_val, cyc);
        end
        void'(pcl_q.pop_front());
      end else begin
        n_fail++;
        $display("FAIL pc_load_unexpected: got 1, required 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    exp_lvl(1, 4, 0, "reset_outputs_c1");
    exp_lvl(2, 4, 0, "reset_outputs_c2");
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // 1: 3-cycle glitch is ignored, held press gives one step 7 cycles later, release silent
    key_n[0] = 1'b0; tick(3); key_n[0] = 1'b1; tick(6);
    k = cyc; key_n[0] = 1'b0; exp_pulse(0, k + 7, 0);
    tick(12); key_n[0] = 1'b1; tick(10);

    // 2: run mode steps every 5 cycles, key0 ignored, second key1 press stops it
    k = cyc; key_n[1] = 1'b0;
    exp_lvl(k + 7, 0, 0, "run_mode_before_toggle");
    exp_lvl(k + 8, 0, 1, "run_mode_on");
    for (int n = 0; n < 5; n++) exp_pulse(0, k + 12 + 5 * n, 0);
    exp_lvl(k + 33, 0, 1, "run_mode_still_on");
    exp_lvl(k + 34, 0, 0, "run_mode_off");
    tick(8); key_n[1] = 1'b1;
    tick(5); key_n[0] = 1'b0;
    tick(8); key_n[0] = 1'b1;
    tick(5); key_n[1] = 1'b0;
    tick(8); key_n[1] = 1'b1;
    tick(12);

    // 3: PC load pulse on rising edge only
    k = cyc; sw_pc_val = 8'hA5; sw_load = 1'b1; exp_pulse(1, k + 3, 'hA5);
    tick(10); sw_load = 1'b0; tick(5);
    k = cyc; sw_pc_val = 8'h3C; sw_load = 1'b1; exp_pulse(1, k + 3, 'h3C);
    tick(6); sw_load = 1'b0; tick(4);

    // 4: LED lane selection and data latency
    ch_data[3*CHW +: CHW] = 32'hDEADBEEF;
    ch_data[7*CHW +: CHW] = 32'h12345678;
    k = cyc; sw_sel = {3'd3, 2'd2}; exp_lvl(k + 3, 1, 'hAD, "leds_ch3_lane2");
    tick(5);
    k = cyc; sw_sel = {3'd3, 2'd0};
    exp_lvl(k + 2, 1, 'hAD, "leds_before_sync");
    exp_lvl(k + 3, 1, 'hEF, "leds_ch3_lane0");
    tick(5);
    k = cyc; sw_sel = {3'd7, 2'd3}; exp_lvl(k + 3, 1, 'h12, "leds_ch7_lane3");
    tick(5);
    k = cyc; ch_data[7*CHW + 24 +: 8] = 8'h9A;
    exp_lvl(k, 1, 'h12, "leds_data_hold");
    exp_lvl(k + 1, 1, 'h9A, "leds_data_update");
    tick(3);

    // 5: sticky error, key2 clear, set wins over clear
    k = cyc; err_in = 1'b1;
    exp_lvl(k, 2, 0, "err_led_idle");
    exp_lvl(k + 1, 2, 1, "err_led_set");
    exp_lvl(k + 5, 2, 1, "err_led_sticky");
    tick(1); err_in = 1'b0; tick(5);
    k = cyc; key_n[2] = 1'b0;
    exp_lvl(k + 7, 2, 1, "err_led_before_clear");
    exp_lvl(k + 8, 2, 0, "err_led_cleared");
    tick(8); key_n[2] = 1'b1; tick(8);
    k = cyc; key_n[2] = 1'b0;
    exp_lvl(k + 8, 2, 1, "err_set_beats_clear");
    exp_lvl(k + 10, 2, 1, "err_set_beats_clear_hold");
    tick(7); err_in = 1'b1; tick(1); err_in = 1'b0;
    tick(1); key_n[2] = 1'b1; tick(10);

    // 6: simultaneous key0+key1 toggles with no step, then async reset mid-run
    k = cyc; key_n[1:0] = 2'b00;
    exp_lvl(k + 8, 0, 1, "run_mode_simul_on");
    exp_pulse(0, k + 12, 0);
    exp_pulse(0, k + 17, 0);
    tick(8); key_n[1:0] = 2'b11;
    tick(10);
    exp_lvl(cyc, 0, 1, "run_mode_before_reset");
    tick(1);
    rst_n = 1'b0;
    exp_lvl(cyc, 4, 0, "async_reset_outputs");
    tick(2); rst_n = 1'b1;
    exp_lvl(cyc + 10, 0, 0, "run_mode_after_reset");
    tick(20);

    n_checks++;
    if (step_q.size() + pcl_q.size() + lvl_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0",
               step_q.size() + pcl_q.size() + lvl_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
